// File: rtl/float_add_seq.sv
// Multi-cycle IEEE-754 single-precision adder/subtractor.
// One operand pair is accepted in IDLE, then the FSM walks ALIGN, ADD,
// iterative NORM and ROUND before holding the packed result in DONE until
// the consumer takes it. Denormal inputs and results flush to signed zero.
module float_add_seq #(
  parameter int unsigned ROUND_MODE = 0  // 0 = round-to-nearest-even, 1 = truncate
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;        // operand B with the subtract flag folded into its sign
  logic [26:0] r_mb;       // big mantissa {hidden, frac, G, R, S}
  logic [26:0] r_ms;       // aligned small mantissa, sticky in bit 0
  logic [9:0]  r_exp;      // extra headroom so overflow is visible before packing
  logic        r_sign;
  logic        r_eff_sub;
  logic [27:0] r_sum;
  logic        r_zero;
  logic [31:0] r_res;
  logic        r_in_ready;
  logic        r_out_valid;
  logic        r_busy;

  logic [7:0]  w_ea;
  logic [7:0]  w_eb;
  logic [26:0] w_ma;
  logic [26:0] w_mb;
  logic        w_a_nan;
  logic        w_b_nan;
  logic        w_special;
  logic [31:0] w_spec_res;
  logic        w_a_big;
  logic [7:0]  w_big_e;
  logic [7:0]  w_small_e;
  logic [26:0] w_big_m;
  logic [26:0] w_small_m;
  logic        w_big_s;
  logic [7:0]  w_d;
  logic [26:0] w_mask;
  logic [26:0] w_shifted;

  logic        w_inc;
  logic [24:0] w_m25;
  logic [9:0]  w_rexp;
  logic [22:0] w_frac;
  logic [31:0] w_pack;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_res;
  assign busy      = r_busy;

  // Unpack captured operands, classify specials, pick the big operand and align the small one.
  always_comb begin
    w_ea      = r_a[30:23];
    w_eb      = r_b[30:23];
    w_ma      = (w_ea == 8'd0) ? '0 : {1'b1, r_a[22:0], 3'b000};
    w_mb      = (w_eb == 8'd0) ? '0 : {1'b1, r_b[22:0], 3'b000};
    w_a_nan   = (w_ea == 8'hFF) && (r_a[22:0] != '0);
    w_b_nan   = (w_eb == 8'hFF) && (r_b[22:0] != '0);
    w_special = (w_ea == 8'hFF) || (w_eb == 8'hFF);
    if (w_a_nan || w_b_nan ||
        ((w_ea == 8'hFF) && (w_eb == 8'hFF) && (r_a[31] != r_b[31]))) begin
      w_spec_res = 32'h7FC0_0000;
    end else if (w_ea == 8'hFF) begin
      w_spec_res = r_a;
    end else begin
      w_spec_res = r_b;
    end
    w_a_big   = (w_ea > w_eb) || ((w_ea == w_eb) && (w_ma >= w_mb));
    w_big_e   = w_a_big ? w_ea : w_eb;
    w_small_e = w_a_big ? w_eb : w_ea;
    w_big_m   = w_a_big ? w_ma : w_mb;
    w_small_m = w_a_big ? w_mb : w_ma;
    w_big_s   = w_a_big ? r_a[31] : r_b[31];
    w_d       = w_big_e - w_small_e;
    w_mask    = ~({27{1'b1}} << w_d);
    if (w_d >= 8'd27) begin
      w_shifted = {26'd0, |w_small_m};
    end else begin
      w_shifted = (w_small_m >> w_d) | {26'd0, |(w_small_m & w_mask)};
    end
  end

  // Round the normalized sum and pack it, saturating to infinity on exponent overflow.
  always_comb begin
    w_inc  = (ROUND_MODE == 0) && r_sum[2] && (r_sum[1] || r_sum[0] || r_sum[3]);
    w_m25  = {1'b0, r_sum[26:3]} + 25'(w_inc);
    w_rexp = r_exp + {9'd0, w_m25[24]};
    w_frac = w_m25[24] ? w_m25[23:1] : w_m25[22:0];
    if (r_zero) begin
      w_pack = {r_sign, 31'd0};
    end else if (w_rexp >= 10'd255) begin
      w_pack = {r_sign, 8'hFF, 23'd0};
    end else begin
      w_pack = {r_sign, w_rexp[7:0], w_frac};
    end
  end

  // Sequencer: capture, align, add, normalize one step per cycle, round, hand off.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_mb        <= '0;
      r_ms        <= '0;
      r_exp       <= '0;
      r_sign      <= 1'b0;
      r_eff_sub   <= 1'b0;
      r_sum       <= '0;
      r_zero      <= 1'b0;
      r_res       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= {b[31] ^ sub, b[30:0]};
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (w_special) begin
            r_res       <= w_spec_res;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_mb      <= w_big_m;
            r_ms      <= w_shifted;
            r_exp     <= {2'b00, w_big_e};
            r_sign    <= w_big_s;
            r_eff_sub <= r_a[31] ^ r_b[31];
            r_state   <= S_ADD;
          end
        end
        S_ADD: begin
          r_sum   <= r_eff_sub ? ({1'b0, r_mb} - {1'b0, r_ms})
                               : ({1'b0, r_mb} + {1'b0, r_ms});
          r_zero  <= 1'b0;
          r_state <= S_NORM;
        end
        S_NORM: begin
          if (r_sum == '0) begin
            r_zero  <= 1'b1;
            r_sign  <= 1'b0;
            r_state <= S_ROUND;
          end else if (r_sum[27]) begin
            r_sum   <= {1'b0, r_sum[27:2], r_sum[1] | r_sum[0]};
            r_exp   <= r_exp + 10'd1;
            r_state <= S_ROUND;
          end else if (!r_sum[26] && (r_exp > 10'd1)) begin
            r_sum <= {r_sum[26:0], 1'b0};
            r_exp <= r_exp - 10'd1;
          end else if (!r_sum[26]) begin
            r_zero  <= 1'b1;
            r_state <= S_ROUND;
          end else begin
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_res       <= w_pack;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_add_seq.sv
// Bench for float_add_seq: directed and random operand pairs, a scoreboard
// fed by the driver and drained by an output monitor, and a double-precision
// reference model for round-to-nearest-even results.
module tb_float_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_ready;
  logic        in_ready0, out_valid0, busy0;
  logic [31:0] result0;
  logic        in_ready1, out_valid1, busy1;
  logic [31:0] result1;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] er;   // expected, round-to-nearest-even instance
    logic [31:0] et;   // expected, truncating instance
    bit          ct;   // truncating expectation is known
    int          acc;  // cycle stamp of the accept
    int          lat;  // exact latency, or -1 for "any normal-path latency"
    int          id;
  } exp_t;

  exp_t sb[$];

  float_add_seq #(.ROUND_MODE(0)) u_rne (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid0), .out_ready(out_ready),
    .result(result0), .busy(busy0)
  );

  float_add_seq #(.ROUND_MODE(1)) u_trn (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Single value -> double, inputs with a zero exponent taken as signed zero.
  function automatic real f2r(input logic [31:0] x);
    logic [63:0] bits;
    logic [10:0] e;
    if (x[30:23] == 8'd0) begin
      bits = {x[31], 63'd0};
    end else begin
      e = 11'(x[30:23]) + 11'd896;
      bits = {x[31], e, x[22:0], 29'd0};
    end
    return $bitstoreal(bits);
  endfunction

  // Double -> single with round-to-nearest-even, flush-to-zero and overflow to inf.
  function automatic logic [31:0] r2f(input real d);
    logic [63:0] bits;
    logic [24:0] m;
    logic [28:0] rest;
    int          e;
    bit          up;
    if (d == 0.0) return 32'h0;
    bits = $realtobits(d);
    e    = int'(bits[62:52]);
    e    = e - 1023 + 127;
    if (e <= 0) return {bits[63], 31'd0};
    m    = {1'b0, 1'b1, bits[51:29]};
    rest = bits[28:0];
    up   = rest[28] && ((rest[27:0] != 0) || m[0]);
    m    = m + 25'(up);
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {bits[63], 8'hFF, 23'd0};
    return {bits[63], 8'(e), m[22:0]};
  endfunction

  function automatic bit is_special(input logic [31:0] x, input logic [31:0] y);
    return (x[30:23] == 8'hFF) || (y[30:23] == 8'hFF);
  endfunction

  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [31:0] yf;
    bit xn, yn, xi, yi;
    yf = {y[31] ^ s, y[30:0]};
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    yn = (yf[30:23] == 8'hFF) && (yf[22:0] != 0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    yi = (yf[30:23] == 8'hFF) && (yf[22:0] == 0);
    if (xn || yn || (xi && yi && (x[31] != yf[31]))) return 32'h7FC0_0000;
    if (xi) return x;
    if (yi) return yf;
    return r2f(f2r(x) + f2r(yf));
  endfunction

  function automatic logic [31:0] rand_f();
    logic        s;
    logic [22:0] f;
    int          r;
    s = 1'($urandom);
    f = 23'($urandom);
    r = $urandom_range(0, 19);
    if (r == 0) return {s, 8'h00, ($urandom_range(0, 1) == 0) ? 23'd0 : f};
    if (r == 1) return {s, 8'hFF, ($urandom_range(0, 1) == 0) ? 23'd0 : (f | 23'd1)};
    if (r == 2) return {s, 8'($urandom_range(252, 254)), f};
    return {s, 8'($urandom_range(1, 254)), f};
  endfunction

  // Second operand biased towards the first one's magnitude to provoke cancellation.
  function automatic logic [31:0] pick_b(input logic [31:0] x);
    int r, e;
    logic [22:0] f;
    r = $urandom_range(0, 3);
    e = int'(x[30:23]);
    if (r == 0 || e == 0 || e == 255) return rand_f();
    if (r == 1) begin
      f = x[22:0] ^ (23'd1 << $urandom_range(0, 22));
      e = e + $urandom_range(0, 2) - 1;
      if (e < 1) e = 1;
      if (e > 254) e = 254;
      return {1'($urandom), 8'(e), ($urandom_range(0, 3) == 0) ? x[22:0] : f};
    end
    e = e + $urandom_range(0, 60) - 30;
    if (e < 1) e = 1;
    if (e > 254) e = 254;
    return {1'($urandom), 8'(e), 23'($urandom)};
  endfunction

  int id_ctr = 0;

  // Present one operand pair, record its expectation once accepted, then wiggle
  // the inputs for a cycle while the block is busy.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                      input logic [31:0] er, input logic [31:0] et, input bit ct,
                      input int lat);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready0) break;
      n++;
      if (n > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, expected 1");
        in_valid = 1'b0;
        return;
      end
    end
    e.er = er; e.et = et; e.ct = ct; e.acc = cyc; e.lat = lat; e.id = id_ctr;
    id_ctr++;
    sb.push_back(e);
    @(posedge clk); #1;
    a = $urandom; b = $urandom; sub = 1'($urandom);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        n_cmp++; n_bad++;
        $display("FAIL done_timeout: got %0d pending results, expected 0", sb.size());
        sb.delete();
      end
    end
  endtask

  // Output monitor: pop the oldest expectation on every result handshake.
  int prev_ov = 0;
  int rise = 0;
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (rst) begin
      prev_ov = 0;
    end else begin
      if (out_valid0 && prev_ov == 0) rise = cyc;
      prev_ov = int'(out_valid0);
      if (out_valid0 && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_output: got result %08h, expected no output", result0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("result_rne#%0d", e.id), result0, e.er);
          chk($sformatf("valid_trn#%0d", e.id), {31'd0, out_valid1}, 32'd1);
          if (e.ct) chk($sformatf("result_trn#%0d", e.id), result1, e.et);
          lat = rise - e.acc;
          if (e.lat >= 0) begin
            chk($sformatf("latency#%0d", e.id), lat, e.lat);
          end else begin
            n_cmp++;
            if (lat < 5 || lat > 31) begin
              n_bad++;
              $display("FAIL latency#%0d: got %0d expected 5..31", e.id, lat);
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no completion, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ta, tbv;
    logic        ts;
    int          seen;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready0}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid0}, 32'd0);
    chk("reset_result", result0, 32'd0);
    chk("reset_busy", {31'd0, busy0}, 32'd0);

    // Directed cases: exact latencies and both rounding modes where known.
    send(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 32'h4000_0000, 1'b1, 5);
    wait_idle();
    send(32'h4040_0000, 32'h3F00_0000, 1'b0, 32'h4060_0000, 32'h4060_0000, 1'b1, 5);
    wait_idle();
    send(32'h4040_0000, 32'h3F00_0000, 1'b1, 32'h4020_0000, 32'h4020_0000, 1'b1, 5);
    wait_idle();
    send(32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 5);
    wait_idle();
    send(32'h3F80_0001, 32'hBF80_0000, 1'b0, 32'h3400_0000, 32'h3400_0000, 1'b1, 28);
    wait_idle();
    send(32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 32'h7FC0_0000, 1'b1, 2);
    wait_idle();
    send(32'h7F80_0000, 32'h3F80_0000, 1'b1, 32'h7F80_0000, 32'h7F80_0000, 1'b1, 2);
    wait_idle();
    send(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 32'h7F80_0000, 1'b1, 5);
    wait_idle();
    send(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 32'h3F80_0000, 1'b1, 5);
    wait_idle();
    send(32'h3F80_0000, 32'h33C0_0000, 1'b0, 32'h3F80_0001, 32'h3F80_0000, 1'b1, 5);
    wait_idle();
    send(32'h3FFF_FFFF, 32'h3F80_0000, 1'b0, 32'h4040_0000, 32'h403F_FFFF, 1'b1, 5);
    wait_idle();
    send(32'h0012_3456, 32'hC0A0_0000, 1'b0, 32'hC0A0_0000, 32'hC0A0_0000, 1'b1, 5);
    wait_idle();

    // Consumer stalls: result and handshake signals must hold.
    out_ready = 1'b0;
    send(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 32'h4000_0000, 1'b1, 5);
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(negedge clk);
      if (out_valid0) seen = 1;
    end
    chk("stall_valid_seen", seen, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_out_valid", {31'd0, out_valid0}, 32'd1);
      chk("stall_result", result0, 32'h4000_0000);
      chk("stall_in_ready", {31'd0, in_ready0}, 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle();
    @(negedge clk);
    chk("after_handshake_valid", {31'd0, out_valid0}, 32'd0);
    chk("after_handshake_in_ready", {31'd0, in_ready0}, 32'd1);

    // Abort while normalizing: nothing may come out.
    send(32'h3F80_0001, 32'hBF80_0000, 1'b0, 32'h3400_0000, 32'h3400_0000, 1'b1, 28);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_in_ready", {31'd0, in_ready0}, 32'd1);
    chk("abort_busy", {31'd0, busy0}, 32'd0);
    chk("abort_out_valid", {31'd0, out_valid0}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid0) seen = 1;
    end
    chk("abort_no_output", seen, 0);

    // Random operand pairs against the reference model.
    for (int i = 0; i < 300; i++) begin
      ta  = rand_f();
      tbv = pick_b(ta);
      ts  = 1'($urandom);
      send(ta, tbv, ts, model(ta, tbv, ts), 32'h0, 1'b0,
           is_special(ta, tbv) ? 2 : -1);
      wait_idle();
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
